// File: rtl/tcam_pkg.sv
// Shared widths and types for the TCAM lookup.
// Segment entry layout: {stt, id}; STT_VALID marks a live entry.
package tcam_pkg;

  localparam int KWID     = 104;
  localparam int NSEG     = KWID / 8;
  localparam int SEGWID   = 10;
  localparam int VTWID    = SEGWID * NSEG;
  localparam int AWID     = 8;
  localparam int DEP      = 256;
  localparam int MASKWID  = KWID / 8;
  localparam int IDWID    = 8;
  localparam int PRIOR    = 8;
  localparam int TOTALWID = KWID + MASKWID + PRIOR;

  localparam logic [1:0] STT_VALID = 2'b01;

  typedef struct packed {
    logic [1:0]       stt;
    logic [IDWID-1:0] id;
  } seg_entry_t;

endpackage

// File: rtl/tcam_segment_engine.sv
// One byte-indexed segment table: 256 x {stt,id}, one write port,
// one registered read port. Ports: wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module tcam_segment_engine
  import tcam_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AWID-1:0] wr_addr,
  input  seg_entry_t      wr_data,
  input  logic [AWID-1:0] rd_addr,
  output seg_entry_t      rd_data
);

  seg_entry_t mem_q [DEP];
  seg_entry_t rd_d;
  seg_entry_t rd_q;

  always_comb begin
    rd_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEP; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/tcam_wrapper.sv
// TCAM lookup top: 13 segment engines nominate candidates, mask/confirm
// tables verify them, highest priority (then lowest ID) wins. Latency 3.
// Ports: clk, rst_n, i_Key -> o_RuleID/o_Invalid; i_Set_* program tables.
module tcam_wrapper
  import tcam_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KWID-1:0]     i_Key,
  output logic [IDWID-1:0]    o_RuleID,
  output logic                o_Invalid,
  input  logic [KWID-1:0]     i_Set_Key,
  input  logic [VTWID-1:0]    i_Set_Vector_ID,
  input  logic                i_Set_Segment_Enable,
  input  logic [IDWID-1:0]    i_Set_Mask_ID,
  input  logic [MASKWID-1:0]  i_Set_Mask_Vector,
  input  logic                i_Set_Mask_Enable,
  input  logic [IDWID-1:0]    i_Set_Confirm_ID,
  input  logic [TOTALWID-1:0] i_Set_Confirm_String,
  input  logic                i_Set_Confirm_Enable
);

  // Mask and confirm tables
  logic [MASKWID-1:0] mask_q [DEP];
  logic [KWID-1:0]    ckey_q [DEP];
  logic [PRIOR-1:0]   prio_q [DEP];
  logic [DEP-1:0]     cvld_q;

  // Confirm string bits between key and priority carry no meaning
  logic unused_conf_bits;
  assign unused_conf_bits =
    ^i_Set_Confirm_String[TOTALWID-PRIOR-1:KWID];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEP; i++) begin
        mask_q[i] <= '0;
        ckey_q[i] <= '0;
        prio_q[i] <= '0;
      end
      cvld_q <= '0;
    end else begin
      if (i_Set_Mask_Enable) begin
        mask_q[i_Set_Mask_ID] <= i_Set_Mask_Vector;
      end
      if (i_Set_Confirm_Enable) begin
        ckey_q[i_Set_Confirm_ID] <=
          i_Set_Confirm_String[KWID-1:0];
        prio_q[i_Set_Confirm_ID] <=
          i_Set_Confirm_String[TOTALWID-1 -: PRIOR];
        cvld_q[i_Set_Confirm_ID] <= 1'b1;
      end
    end
  end

  // Stage 1: segment reads are registered inside the engines
  seg_entry_t seg_rd [NSEG];

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    tcam_segment_engine u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (i_Set_Segment_Enable),
      .wr_addr (i_Set_Key[8*s +: 8]),
      .wr_data (seg_entry_t'(i_Set_Vector_ID[SEGWID*s +: SEGWID])),
      .rd_addr (i_Key[8*s +: 8]),
      .rd_data (seg_rd[s])
    );
  end

  logic [KWID-1:0] key1_d, key1_q;

  assign key1_d = i_Key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key1_q <= '0;
    else        key1_q <= key1_d;
  end

  // Stage 2: fetch mask/confirm entries of each candidate
  logic [KWID-1:0]    key2_d, key2_q;
  logic [NSEG-1:0]    hit2_d, hit2_q;
  logic [IDWID-1:0]   cid2_d  [NSEG];
  logic [IDWID-1:0]   cid2_q  [NSEG];
  logic [MASKWID-1:0] mask2_d [NSEG];
  logic [MASKWID-1:0] mask2_q [NSEG];
  logic [KWID-1:0]    ckey2_d [NSEG];
  logic [KWID-1:0]    ckey2_q [NSEG];
  logic [PRIOR-1:0]   prio2_d [NSEG];
  logic [PRIOR-1:0]   prio2_q [NSEG];

  always_comb begin
    key2_d = key1_q;
    hit2_d = '0;
    for (int s = 0; s < NSEG; s++) begin
      cid2_d[s]  = seg_rd[s].id;
      hit2_d[s]  = (seg_rd[s].stt == STT_VALID) &&
                   cvld_q[seg_rd[s].id];
      mask2_d[s] = mask_q[seg_rd[s].id];
      ckey2_d[s] = ckey_q[seg_rd[s].id];
      prio2_d[s] = prio_q[seg_rd[s].id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key2_q <= '0;
      hit2_q <= '0;
      for (int s = 0; s < NSEG; s++) begin
        cid2_q[s]  <= '0;
        mask2_q[s] <= '0;
        ckey2_q[s] <= '0;
        prio2_q[s] <= '0;
      end
    end else begin
      key2_q <= key2_d;
      hit2_q <= hit2_d;
      for (int s = 0; s < NSEG; s++) begin
        cid2_q[s]  <= cid2_d[s];
        mask2_q[s] <= mask2_d[s];
        ckey2_q[s] <= ckey2_d[s];
        prio2_q[s] <= prio2_d[s];
      end
    end
  end

  // Stage 3: confirm and pick the winner
  logic             match;
  logic             found;
  logic [IDWID-1:0] best_id;
  logic [PRIOR-1:0] best_prio;
  logic [IDWID-1:0] rule_d, rule_q;
  logic             inv_d, inv_q;

  always_comb begin
    match     = 1'b0;
    found     = 1'b0;
    best_id   = '0;
    best_prio = '0;
    for (int s = 0; s < NSEG; s++) begin
      match = hit2_q[s];
      for (int b = 0; b < MASKWID; b++) begin
        if (!mask2_q[s][b] &&
            key2_q[8*b +: 8] != ckey2_q[s][8*b +: 8]) begin
          match = 1'b0;
        end
      end
      if (match &&
          (!found || prio2_q[s] > best_prio ||
           (prio2_q[s] == best_prio && cid2_q[s] < best_id))) begin
        found     = 1'b1;
        best_id   = cid2_q[s];
        best_prio = prio2_q[s];
      end
    end
    rule_d = found ? best_id : '0;
    inv_d  = !found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_q <= '0;
      inv_q  <= 1'b1;
    end else begin
      rule_q <= rule_d;
      inv_q  <= inv_d;
    end
  end

  assign o_RuleID  = rule_q;
  assign o_Invalid = inv_q;

endmodule

// File: tb/tb_tcam_wrapper.sv
// Randomized + directed bench for tcam_wrapper against a
// rule-table reference model.
module tb_tcam_wrapper;

  logic         clk;
  logic         rst_n;
  logic [103:0] i_Key;
  logic [7:0]   o_RuleID;
  logic         o_Invalid;
  logic [103:0] i_Set_Key;
  logic [129:0] i_Set_Vector_ID;
  logic         i_Set_Segment_Enable;
  logic [7:0]   i_Set_Mask_ID;
  logic [12:0]  i_Set_Mask_Vector;
  logic         i_Set_Mask_Enable;
  logic [7:0]   i_Set_Confirm_ID;
  logic [124:0] i_Set_Confirm_String;
  logic         i_Set_Confirm_Enable;

  tcam_wrapper dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_Key                (i_Key),
    .o_RuleID             (o_RuleID),
    .o_Invalid            (o_Invalid),
    .i_Set_Key            (i_Set_Key),
    .i_Set_Vector_ID      (i_Set_Vector_ID),
    .i_Set_Segment_Enable (i_Set_Segment_Enable),
    .i_Set_Mask_ID        (i_Set_Mask_ID),
    .i_Set_Mask_Vector    (i_Set_Mask_Vector),
    .i_Set_Mask_Enable    (i_Set_Mask_Enable),
    .i_Set_Confirm_ID     (i_Set_Confirm_ID),
    .i_Set_Confirm_String (i_Set_Confirm_String),
    .i_Set_Confirm_Enable (i_Set_Confirm_Enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  // Reference model: the programmed tables as plain arrays
  bit [1:0]   m_stt [13][256];
  bit [7:0]   m_sid [13][256];
  bit [12:0]  m_mask [256];
  bit [103:0] m_key [256];
  bit [7:0]   m_prio [256];
  bit         m_cv [256];

  bit [103:0] sq[$];
  bit [8:0]   eq[$];

  localparam bit [103:0] K_R1 = 104'h40_5B_6A_00_A4_68_00_00_FF_FF_FF_FF_FF;
  localparam bit [103:0] K_R4 = 104'hC0_97_0B_00_00_00_00_00_FF_FF_FF_FF_FF;
  localparam bit [103:0] K_R5 = 104'hC0_97_0B_11_00_00_00_00_FF_FF_FF_FF_FF;
  localparam bit [103:0] K_W5 = 104'h5F_69_8F_26_0F_00_00_00_FF_FF_FF_FF_FF;
  localparam bit [103:0] K_R8 = 104'h12_34_56_00_00_00_00_00_FF_FF_FF_FF_FF;
  localparam bit [103:0] K_KP = 104'hAB_CD_EF_10_20_30_40_50_60_70_80_90_A0;
  localparam bit [103:0] K_KW = 104'h77_66_55_44_33_22_11_00_13_57_9B_DF_EE;
  localparam bit [95:0]  TAIL = 96'h01_02_03_04_05_06_07_08_09_0A_0B_0C;

  function automatic void model_reset();
    for (int s = 0; s < 13; s++)
      for (int a = 0; a < 256; a++) m_stt[s][a] = 2'b00;
    for (int a = 0; a < 256; a++) begin
      m_cv[a]   = 1'b0;
      m_mask[a] = '0;
    end
  endfunction

  function automatic bit rule_matches(input int id, input bit [103:0] k);
    for (int b = 0; b < 13; b++)
      if (!m_mask[id][b] && k[8*b +: 8] != m_key[id][8*b +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {invalid, id}
  function automatic bit [8:0] model_lookup(input bit [103:0] k);
    bit cand [256];
    int best;
    bit [7:0] a;
    for (int i = 0; i < 256; i++) cand[i] = 1'b0;
    for (int s = 0; s < 13; s++) begin
      a = k[8*s +: 8];
      if (m_stt[s][a] == 2'b01) cand[m_sid[s][a]] = 1'b1;
    end
    best = -1;
    for (int id = 0; id < 256; id++)
      if (cand[id] && m_cv[id] && rule_matches(id, k))
        if (best < 0 || m_prio[id] > m_prio[best]) best = id;
    if (best < 0) return {1'b1, 8'h00};
    return {1'b0, 8'(best)};
  endfunction

  // Starts and ends just after a falling edge
  task automatic wr(input bit se, input bit [103:0] sk,
                    input bit [129:0] vec, input bit me,
                    input bit [7:0] mid, input bit [12:0] mv,
                    input bit ce, input bit [7:0] cid,
                    input bit [124:0] cs);
    i_Set_Segment_Enable = se;
    i_Set_Key            = sk;
    i_Set_Vector_ID      = vec;
    i_Set_Mask_Enable    = me;
    i_Set_Mask_ID        = mid;
    i_Set_Mask_Vector    = mv;
    i_Set_Confirm_Enable = ce;
    i_Set_Confirm_ID     = cid;
    i_Set_Confirm_String = cs;
    @(posedge clk);
    if (se)
      for (int s = 0; s < 13; s++) begin
        m_stt[s][sk[8*s +: 8]] = vec[10*s+8 +: 2];
        m_sid[s][sk[8*s +: 8]] = vec[10*s +: 8];
      end
    if (me) m_mask[mid] = mv;
    if (ce) begin
      m_key[cid]  = cs[103:0];
      m_prio[cid] = cs[124:117];
      m_cv[cid]   = 1'b1;
    end
    @(negedge clk);
    i_Set_Segment_Enable = 1'b0;
    i_Set_Mask_Enable    = 1'b0;
    i_Set_Confirm_Enable = 1'b0;
  endtask

  function automatic bit [129:0] vec_all(input bit [7:0] id);
    bit [129:0] v;
    for (int s = 0; s < 13; s++) v[10*s +: 10] = {2'b01, id};
    return v;
  endfunction

  function automatic bit [124:0] cstr(input bit [7:0] p,
                                      input bit [103:0] k);
    return {p, 13'h1A5A, k};
  endfunction

  task automatic prog_rule(input bit [7:0] id, input bit [103:0] k,
                           input bit [12:0] m, input bit [7:0] p);
    wr(1'b1, k, vec_all(id), 1'b1, id, m, 1'b1, id, cstr(p, k));
  endtask

  // Issue sq back-to-back, one per cycle; check eq 3 edges later
  task automatic run_stream(input string nm);
    int n;
    n = sq.size();
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        n_run++;
        if ({o_Invalid, o_RuleID} !== eq[i-3]) begin
          n_fail++;
          $display("FAIL %s[%0d]: got inv=%0b id=%02h, want inv=%0b id=%02h",
                   nm, i-3, o_Invalid, o_RuleID, eq[i-3][8], eq[i-3][7:0]);
        end
      end
      if (i < n) i_Key = sq[i];
      @(negedge clk);
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic check_reset_out(input string nm);
    n_run++;
    if (o_Invalid !== 1'b1 || o_RuleID !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: got inv=%0b id=%02h, want inv=1 id=00",
               nm, o_Invalid, o_RuleID);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_out("reset_out");
    // A write while held in reset must be dropped
    i_Set_Segment_Enable = 1'b1;
    i_Set_Key            = K_R1;
    i_Set_Vector_ID      = vec_all(8'h00);
    i_Set_Confirm_Enable = 1'b1;
    i_Set_Confirm_ID     = 8'h00;
    i_Set_Confirm_String = cstr(8'h00, K_R1);
    i_Key                = K_R1;
    @(negedge clk);
    i_Set_Segment_Enable = 1'b0;
    i_Set_Confirm_Enable = 1'b0;
    check_reset_out("reset_out_held");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    sq.push_back(K_R1);
    eq.push_back({1'b1, 8'h00});
    run_stream("reset_search");
  endtask

  task automatic test_single_rule();
    prog_rule(8'h00, K_R1, 13'b0001001100000, 8'h00);
    sq.push_back(K_R1);
    eq.push_back({1'b0, 8'h00});
    run_stream("r1_search");
  endtask

  task automatic test_ten_rules();
    bit [103:0] k [10];
    bit [12:0]  m [10];
    for (int i = 0; i < 10; i++) m[i] = '0;
    k[0] = K_R1;  m[0] = 13'b0001001100000;
    k[1] = {8'h21, TAIL};
    k[2] = {8'h31, TAIL};
    k[3] = K_R4;  m[3] = 13'b0001011100000;
    k[4] = K_R5;
    k[5] = K_W5;  m[5] = 13'b0000011100000;
    k[6] = {8'h66, TAIL};
    k[7] = K_R8;
    k[8] = {8'h88, TAIL};
    k[9] = {8'h99, TAIL};
    for (int i = 0; i < 10; i++)
      prog_rule(8'(i), k[i], m[i], 8'(i));
    for (int i = 0; i < 10; i++) begin
      sq.push_back(k[i]);
      eq.push_back(i == 3 ? {1'b1, 8'h00} : {1'b0, 8'(i)});
    end
    run_stream("ten_rules");
  endtask

  task automatic test_wildcard();
    sq.push_back(104'h5F_69_8F_26_0F_AA_BB_CC_FF_FF_FF_FF_FF);
    eq.push_back({1'b0, 8'h05});
    sq.push_back(104'h5F_69_8F_27_0F_AA_BB_CC_FF_FF_FF_FF_FF);
    eq.push_back({1'b1, 8'h00});
    run_stream("wildcard");
  endtask

  task automatic test_priority();
    bit [129:0] v;
    for (int s = 0; s < 13; s++)
      v[10*s +: 10] = (s < 7) ? {2'b01, 8'h02} : {2'b01, 8'h07};
    wr(1'b1, K_KP, v, 1'b1, 8'h07, '0, 1'b1, 8'h07, cstr(8'd3, K_KP));
    wr(1'b0, '0, '0, 1'b1, 8'h02, '0, 1'b1, 8'h02, cstr(8'd9, K_KP));
    sq.push_back(K_KP);
    eq.push_back({1'b0, 8'h02});
    run_stream("prio_high_wins");
    wr(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 8'h07, cstr(8'd10, K_KP));
    sq.push_back(K_KP);
    eq.push_back({1'b0, 8'h07});
    run_stream("prio_swap");
    wr(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 8'h07, cstr(8'd9, K_KP));
    sq.push_back(K_KP);
    eq.push_back({1'b0, 8'h02});
    run_stream("prio_tie_low_id");
  endtask

  task automatic test_back_to_back();
    sq.push_back(K_R1);  eq.push_back({1'b0, 8'h00});
    sq.push_back(K_KP);  eq.push_back({1'b0, 8'h02});
    sq.push_back(104'h5F_69_8F_26_0F_AA_BB_CC_FF_FF_FF_FF_FF);
    eq.push_back({1'b0, 8'h05});
    sq.push_back(K_R4);  eq.push_back({1'b1, 8'h00});
    run_stream("back_to_back");
  endtask

  task automatic test_write_during_search();
    bit [8:0] exp [2];
    wr(1'b0, '0, '0, 1'b1, 8'd20, '0, 1'b1, 8'd20, cstr(8'd1, K_KW));
    // Search and segment write share an edge: the search sees old data
    exp[0] = {1'b1, 8'h00};
    exp[1] = {1'b0, 8'd20};
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) begin
        n_run++;
        if ({o_Invalid, o_RuleID} !== exp[i-3]) begin
          n_fail++;
          $display("FAIL wr_during_search[%0d]: got inv=%0b id=%02h, want inv=%0b id=%02h",
                   i-3, o_Invalid, o_RuleID, exp[i-3][8], exp[i-3][7:0]);
        end
      end
      i_Key = K_KW;
      i_Set_Segment_Enable = (i == 0);
      i_Set_Key = K_KW;
      i_Set_Vector_ID = vec_all(8'd20);
      @(negedge clk);
      if (i == 0)
        for (int s = 0; s < 13; s++) begin
          m_stt[s][K_KW[8*s +: 8]] = 2'b01;
          m_sid[s][K_KW[8*s +: 8]] = 8'd20;
        end
    end
    i_Set_Segment_Enable = 1'b0;
  endtask

  task automatic test_random();
    bit [103:0] rk [6];
    bit [12:0]  rm [6];
    bit [127:0] t;
    bit [103:0] k;
    int r;
    for (int j = 0; j < 6; j++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      rk[j] = t[103:0];
      rm[j] = 13'($urandom) & 13'($urandom);
      prog_rule(8'($urandom_range(32, 255)), rk[j], rm[j], 8'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 5);
      k = rk[r];
      for (int b = 0; b < 13; b++)
        if (rm[r][b]) k[8*b +: 8] = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        k[8*$urandom_range(0, 12) +: 8] ^= 8'h5A;
      sq.push_back(k);
      eq.push_back(model_lookup(k));
    end
    run_stream("random");
  endtask

  task automatic test_reset_midflight();
    bit [103:0] k30;
    i_Key = K_R1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_out("reset_midflight");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sq.push_back(K_R1);
    eq.push_back({1'b1, 8'h00});
    run_stream("after_reset_r1");
    // Mask table cleared: with no mask write every byte must match
    k30 = 104'h30_31_32_33_34_35_36_37_38_39_3A_3B_3C;
    wr(1'b1, k30, vec_all(8'd30), 1'b0, '0, '0, 1'b1, 8'd30, cstr(8'd4, k30));
    sq.push_back(k30);
    eq.push_back({1'b0, 8'd30});
    k30[31:24] = 8'hEE;
    sq.push_back(k30);
    eq.push_back({1'b1, 8'h00});
    run_stream("after_reset_mask");
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    i_Key = '0;
    i_Set_Key = '0;
    i_Set_Vector_ID = '0;
    i_Set_Segment_Enable = 1'b0;
    i_Set_Mask_ID = '0;
    i_Set_Mask_Vector = '0;
    i_Set_Mask_Enable = 1'b0;
    i_Set_Confirm_ID = '0;
    i_Set_Confirm_String = '0;
    i_Set_Confirm_Enable = 1'b0;
    model_reset();
    test_reset();
    test_single_rule();
    test_ten_rules();
    test_wildcard();
    test_priority();
    test_back_to_back();
    test_write_during_search();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
